unidade_controle_escrita: RTL and testbench
===========================================

Name: unidade_controle_escrita

Overview:
Moore FSM that sequences the memory-game datapath in "write mode". Each round, the player repeats the stored sequence; on a full match, the player enters one new element, which is written to RAM, and the next round starts.
Drives every counter, register, RAM and inactivity-timer control of the datapath and reports the game result.
Sits between the top-level game module and the datapath; its inputs are datapath status signals and the start button.

Parameters:
- ESTADO_W, 4, width of the state register and of db_estado.

Ports:
- clock  in  1  system clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high; returns FSM to INICIAL.
- iniciar  in  1  start / restart request (level, sampled each edge).
- jogada_feita  in  1  one-cycle pulse, new button press detected.
- jogada_igual  in  1  memory data equals registered play.
- fim_rodada  in  1  play address equals round counter.
- fim_jogo  in  1  round counter at terminal value (15).
- inativo  in  1  inactivity timer expired.
- zera_jogada, conta_jogada  out  1  play-address counter clear / increment.
- zera_rodada, conta_rodada  out  1  round counter clear / increment.
- zeraR, registraR  out  1  play register clear / load.
- zeraInativo, contaInativo  out  1  inactivity timer clear / enable.
- ramWE  out  1  RAM write enable (write data = registered play, address = play counter).
- pronto  out  1  game over (any terminal state).
- acertou, errou, timeout  out  1  result flags.
- db_estado  out  4  current state code, for debug display.

Behaviour:
- Moore outputs, decoded only from the state register. No input-to-output combinational path.
- Reset: state is INICIAL on the edge after reset=1. Reset mid-game aborts immediately. All outputs are 0 in INICIAL.
- States, codes, asserted outputs, and transitions:
  - INICIAL 0x0: none. iniciar goes to PREPARA.
  - PREPARA 0x1: zera_jogada, zera_rodada, zeraR, zeraInativo. Goes to INICIA_RODADA.
  - INICIA_RODADA 0x2: zera_jogada, zeraInativo. Goes to ESPERA.
  - ESPERA 0x3: contaInativo. jogada_feita goes to REGISTRA; otherwise inativo goes to FIM_TIMEOUT. jogada_feita has priority when both are high.
  - REGISTRA 0x4: registraR, zeraInativo. Goes to COMPARA.
  - COMPARA 0x5: none.
    - !jogada_igual: FIM_ERRO.
    - jogada_igual and !fim_rodada: PROX_JOGADA.
    - jogada_igual, fim_rodada, fim_jogo: FIM_ACERTO.
    - jogada_igual, fim_rodada, !fim_jogo: PROX_ESCRITA.
  - PROX_JOGADA 0x6: conta_jogada. Goes to ESPERA.
  - PROX_ESCRITA 0x7: conta_jogada, zeraInativo. Goes to ESPERA_ESCRITA.
  - ESPERA_ESCRITA 0x8: contaInativo. jogada_feita goes to REGISTRA_ESCRITA (priority); otherwise inativo goes to FIM_TIMEOUT.
  - REGISTRA_ESCRITA 0x9: registraR. Goes to ESCREVE.
  - ESCREVE 0xA: ramWE. Goes to PROX_RODADA.
  - PROX_RODADA 0xB: conta_rodada. Goes to INICIA_RODADA.
  - FIM_ACERTO 0xC: pronto, acertou.
  - FIM_ERRO 0xD: pronto, errou.
  - FIM_TIMEOUT 0xE: pronto, timeout.
- Terminal states hold until iniciar, then go to PREPARA (restart without reset).
- iniciar is ignored in all non-terminal states except INICIAL.
- Unused code 0xF goes to INICIAL next edge, with all outputs 0.
- Latency: jogada_feita in ESPERA to compare decision in COMPARA takes 2 edges. jogada_feita in ESPERA_ESCRITA to ramWE takes 2 edges.
- Wrap-around: the play counter never passes the round counter, because fim_rodada redirects to PROX_ESCRITA. fim_jogo ends the game before the round counter wraps.

Optional Feature:
- TIMEOUT_EN defined: inativo transitions from ESPERA and ESPERA_ESCRITA are active, and FIM_TIMEOUT is reachable.
- TIMEOUT_EN undefined:
  - inativo is ignored.
  - contaInativo is held at 0.
  - timeout is tied to 0.
  - FIM_TIMEOUT is unreachable; if entered, it behaves as code 0xF.

Decomposition:
- Shared package jogo_pkg holds the 4-bit state code localparams (INICIAL through FIM_TIMEOUT) so datapath debug and display decoding use the same codes.
- No sub-module: state register, next-state logic and output decode stay in one module.

Test Plan:
- Reset, then iniciar=1 for one cycle: db_estado goes 0x0→0x1→0x2→0x3; zera_rodada=1 only in 0x1.
- Round 0, correct play (jogada_feita with jogada_igual=1, fim_rodada=1, fim_jogo=0), then a second press: sequence 0x4,0x5,0x7,0x8,0x9,0xA,0xB,0x2; ramWE high exactly one cycle; conta_rodada high exactly one cycle.
- Wrong play (jogada_igual=0) in COMPARA: goes to 0xD, errou=1, pronto=1; later iniciar=1 goes to 0x1 and errou=0.
- Full match with fim_jogo=1: goes to 0xC, acertou=1, pronto=1.
- ESPERA with jogada_feita=1 and inativo=1 on the same edge: goes to 0x4. inativo alone goes to 0xE with timeout=1 when TIMEOUT_EN is defined; the FSM stays at 0x3 when it is not.
- reset=1 asserted in ESPERA_ESCRITA: next edge db_estado=0x0, all outputs 0, no ramWE pulse.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared state codes for the memory-game write-mode controller, also used by
// the datapath debug and display decoding.
package jogo_pkg;

   localparam int ESTADO_BITS = 4;

   typedef enum logic [ESTADO_BITS-1:0] {
      INICIAL          = 4'h0,
      PREPARA          = 4'h1,
      INICIA_RODADA    = 4'h2,
      ESPERA           = 4'h3,
      REGISTRA         = 4'h4,
      COMPARA          = 4'h5,
      PROX_JOGADA      = 4'h6,
      PROX_ESCRITA     = 4'h7,
      ESPERA_ESCRITA   = 4'h8,
      REGISTRA_ESCRITA = 4'h9,
      ESCREVE          = 4'hA,
      PROX_RODADA      = 4'hB,
      FIM_ACERTO       = 4'hC,
      FIM_ERRO         = 4'hD,
      FIM_TIMEOUT      = 4'hE
   } estado_t;

endpackage

// File: rtl/unidade_controle_escrita.sv
// Write-mode Moore FSM for the memory game: replay the sequence, then append one
// new element per round. Inactivity timeout exists only when TIMEOUT_EN is defined.
//
// state            | meaning
// INICIAL          | idle, waits for iniciar
// PREPARA          | clears round/play counters, play register, timer
// INICIA_RODADA    | rewinds play address for a new round
// ESPERA           | waits for a press while replaying the sequence
// REGISTRA         | latches the pressed button
// COMPARA          | decides match / next play / write / end
// PROX_JOGADA      | advances play address
// PROX_ESCRITA     | advances play address to the slot for the new element
// ESPERA_ESCRITA   | waits for the new element press
// REGISTRA_ESCRITA | latches the new element
// ESCREVE          | writes the new element to RAM
// PROX_RODADA      | advances round counter
// FIM_ACERTO       | game won
// FIM_ERRO         | wrong play
// FIM_TIMEOUT      | player inactive too long
module unidade_controle_escrita
   import jogo_pkg::*;
#(
   parameter int ESTADO_W = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                iniciar,
   input  logic                jogada_feita,
   input  logic                jogada_igual,
   input  logic                fim_rodada,
   input  logic                fim_jogo,
   input  logic                inativo,
   output logic                zera_jogada,
   output logic                conta_jogada,
   output logic                zera_rodada,
   output logic                conta_rodada,
   output logic                zeraR,
   output logic                registraR,
   output logic                zeraInativo,
   output logic                contaInativo,
   output logic                ramWE,
   output logic                pronto,
   output logic                acertou,
   output logic                errou,
   output logic                timeout,
   output logic [ESTADO_W-1:0] db_estado
);

   estado_t r_estado;
   estado_t w_prox;

`ifndef TIMEOUT_EN
   logic w_inativo_unused;
   assign w_inativo_unused = inativo;
`endif

   always_ff @(posedge clock) begin
      if (reset) r_estado <= INICIAL;
      else       r_estado <= w_prox;
   end

   always_comb begin
      w_prox = INICIAL;
      case (r_estado)
         INICIAL:          w_prox = iniciar ? PREPARA : INICIAL;
         PREPARA:          w_prox = INICIA_RODADA;
         INICIA_RODADA:    w_prox = ESPERA;
`ifdef TIMEOUT_EN
         ESPERA:           w_prox = jogada_feita ? REGISTRA
                                  : (inativo ? FIM_TIMEOUT : ESPERA);
`else
         ESPERA:           w_prox = jogada_feita ? REGISTRA : ESPERA;
`endif
         REGISTRA:         w_prox = COMPARA;
         COMPARA: begin
            if (!jogada_igual)    w_prox = FIM_ERRO;
            else if (!fim_rodada) w_prox = PROX_JOGADA;
            else if (fim_jogo)    w_prox = FIM_ACERTO;
            else                  w_prox = PROX_ESCRITA;
         end
         PROX_JOGADA:      w_prox = ESPERA;
         PROX_ESCRITA:     w_prox = ESPERA_ESCRITA;
`ifdef TIMEOUT_EN
         ESPERA_ESCRITA:   w_prox = jogada_feita ? REGISTRA_ESCRITA
                                  : (inativo ? FIM_TIMEOUT : ESPERA_ESCRITA);
`else
         ESPERA_ESCRITA:   w_prox = jogada_feita ? REGISTRA_ESCRITA : ESPERA_ESCRITA;
`endif
         REGISTRA_ESCRITA: w_prox = ESCREVE;
         ESCREVE:          w_prox = PROX_RODADA;
         PROX_RODADA:      w_prox = INICIA_RODADA;
         FIM_ACERTO:       w_prox = iniciar ? PREPARA : FIM_ACERTO;
         FIM_ERRO:         w_prox = iniciar ? PREPARA : FIM_ERRO;
`ifdef TIMEOUT_EN
         FIM_TIMEOUT:      w_prox = iniciar ? PREPARA : FIM_TIMEOUT;
`endif
         default:          w_prox = INICIAL;
      endcase
   end

   // Outputs depend on r_estado only, so no input reaches an output combinationally.
   always_comb begin
      zera_jogada  = 1'b0;
      conta_jogada = 1'b0;
      zera_rodada  = 1'b0;
      conta_rodada = 1'b0;
      zeraR        = 1'b0;
      registraR    = 1'b0;
      zeraInativo  = 1'b0;
      contaInativo = 1'b0;
      ramWE        = 1'b0;
      pronto       = 1'b0;
      acertou      = 1'b0;
      errou        = 1'b0;
      timeout      = 1'b0;
      case (r_estado)
         PREPARA: begin
            zera_jogada = 1'b1;
            zera_rodada = 1'b1;
            zeraR       = 1'b1;
            zeraInativo = 1'b1;
         end
         INICIA_RODADA: begin
            zera_jogada = 1'b1;
            zeraInativo = 1'b1;
         end
`ifdef TIMEOUT_EN
         ESPERA:           contaInativo = 1'b1;
         ESPERA_ESCRITA:   contaInativo = 1'b1;
`endif
         REGISTRA: begin
            registraR   = 1'b1;
            zeraInativo = 1'b1;
         end
         PROX_JOGADA:      conta_jogada = 1'b1;
         PROX_ESCRITA: begin
            conta_jogada = 1'b1;
            zeraInativo  = 1'b1;
         end
         REGISTRA_ESCRITA: registraR    = 1'b1;
         ESCREVE:          ramWE        = 1'b1;
         PROX_RODADA:      conta_rodada = 1'b1;
         FIM_ACERTO: begin
            pronto  = 1'b1;
            acertou = 1'b1;
         end
         FIM_ERRO: begin
            pronto = 1'b1;
            errou  = 1'b1;
         end
`ifdef TIMEOUT_EN
         FIM_TIMEOUT: begin
            pronto  = 1'b1;
            timeout = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign db_estado = ESTADO_W'(r_estado);

endmodule

// File: tb/tb_unidade_controle_escrita.sv
// Scoreboard bench for unidade_controle_escrita: expected state and output
// vector are queued per driven cycle and compared after each rising edge.
module tb_unidade_controle_escrita;

   logic       clock = 1'b0;
   logic       reset, iniciar, jogada_feita, jogada_igual, fim_rodada, fim_jogo, inativo;
   logic       zera_jogada, conta_jogada, zera_rodada, conta_rodada, zeraR, registraR;
   logic       zeraInativo, contaInativo, ramWE, pronto, acertou, errou, timeout;
   logic [3:0] db_estado;

   int         n_checks   = 0;
   int         n_failures = 0;
   int         ciclo      = 0;
   logic [16:0] sb_q[$];

   always #5 clock = ~clock;

   unidade_controle_escrita #(.ESTADO_W(4)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
      .jogada_igual(jogada_igual), .fim_rodada(fim_rodada), .fim_jogo(fim_jogo),
      .inativo(inativo), .zera_jogada(zera_jogada), .conta_jogada(conta_jogada),
      .zera_rodada(zera_rodada), .conta_rodada(conta_rodada), .zeraR(zeraR),
      .registraR(registraR), .zeraInativo(zeraInativo), .contaInativo(contaInativo),
      .ramWE(ramWE), .pronto(pronto), .acertou(acertou), .errou(errou),
      .timeout(timeout), .db_estado(db_estado)
   );

`ifdef TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   // Vector order: zj cj zr cr zR rR zI cI we pr ac er to
   function automatic logic [12:0] exp_outs(input logic [3:0] st);
      case (st)
         4'h1:    return 13'b1_0_1_0_1_0_1_0_0_0_0_0_0;
         4'h2:    return 13'b1_0_0_0_0_0_1_0_0_0_0_0_0;
         4'h3:    return {7'b0, TO_EN, 5'b0};
         4'h4:    return 13'b0_0_0_0_0_1_1_0_0_0_0_0_0;
         4'h6:    return 13'b0_1_0_0_0_0_0_0_0_0_0_0_0;
         4'h7:    return 13'b0_1_0_0_0_0_1_0_0_0_0_0_0;
         4'h8:    return {7'b0, TO_EN, 5'b0};
         4'h9:    return 13'b0_0_0_0_0_1_0_0_0_0_0_0_0;
         4'hA:    return 13'b0_0_0_0_0_0_0_0_1_0_0_0_0;
         4'hB:    return 13'b0_0_0_1_0_0_0_0_0_0_0_0_0;
         4'hC:    return 13'b0_0_0_0_0_0_0_0_0_1_1_0_0;
         4'hD:    return 13'b0_0_0_0_0_0_0_0_0_1_0_1_0;
         4'hE:    return {9'b0, TO_EN, 2'b0, TO_EN};
         default: return 13'b0;
      endcase
   endfunction

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_checks++;
      if (obs !== esp) begin
         n_failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
      end
   endtask

   // Drives one cycle of inputs, queues the expected result after the edge, then checks it.
   task automatic passo(input logic rst, ini, jf, ji, fr, fj, ina, input logic [3:0] esp_st);
      logic [16:0] esp;
      logic [12:0] obs_outs;
      reset = rst; iniciar = ini; jogada_feita = jf;
      jogada_igual = ji; fim_rodada = fr; fim_jogo = fj; inativo = ina;
      sb_q.push_back({esp_st, exp_outs(esp_st)});
      @(posedge clock);
      #1;
      ciclo++;
      obs_outs = {zera_jogada, conta_jogada, zera_rodada, conta_rodada, zeraR, registraR,
                  zeraInativo, contaInativo, ramWE, pronto, acertou, errou, timeout};
      if (sb_q.size() == 0) begin
         verifica($sformatf("scoreboard_vazio@%0d", ciclo), 32'd0, 32'd1);
      end else begin
         esp = sb_q.pop_front();
         verifica($sformatf("estado@%0d", ciclo), 32'(db_estado), 32'(esp[16:13]));
         verifica($sformatf("saidas@%0d", ciclo), 32'(obs_outs), 32'(esp[12:0]));
      end
   endtask

   initial begin
      // reset and start
      passo(1, 0, 0, 0, 0, 0, 0, 4'h0);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h0);
      passo(0, 1, 0, 0, 0, 0, 0, 4'h1);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h2);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h3);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h3);
      // round 0 correct play, then new element written
      passo(0, 0, 1, 0, 0, 0, 0, 4'h4);
      passo(0, 0, 0, 1, 1, 0, 0, 4'h5);
      passo(0, 0, 0, 1, 1, 0, 0, 4'h7);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h8);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h8);
      passo(0, 0, 1, 0, 0, 0, 0, 4'h9);
      passo(0, 0, 0, 0, 0, 0, 0, 4'hA);
      passo(0, 0, 0, 0, 0, 0, 0, 4'hB);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h2);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h3);
      // mid-round correct play, then wrong play
      passo(0, 0, 1, 0, 0, 0, 0, 4'h4);
      passo(0, 0, 0, 1, 0, 0, 0, 4'h5);
      passo(0, 0, 0, 1, 0, 0, 0, 4'h6);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h3);
      passo(0, 0, 1, 0, 0, 0, 0, 4'h4);
      passo(0, 0, 0, 0, 1, 1, 0, 4'h5);
      passo(0, 0, 0, 0, 1, 1, 0, 4'hD);
      passo(0, 0, 0, 0, 0, 0, 0, 4'hD);
      passo(0, 1, 0, 0, 0, 0, 0, 4'h1);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h2);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h3);
      // iniciar ignored while playing; press wins over inativo; full match ends game
      passo(0, 1, 0, 0, 0, 0, 0, 4'h3);
      passo(0, 0, 1, 0, 0, 0, 1, 4'h4);
      passo(0, 0, 0, 1, 1, 1, 0, 4'h5);
      passo(0, 0, 0, 1, 1, 1, 0, 4'hC);
      passo(0, 0, 0, 0, 0, 0, 0, 4'hC);
      passo(0, 1, 0, 0, 0, 0, 0, 4'h1);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h2);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h3);
      // inativo alone
`ifdef TIMEOUT_EN
      passo(0, 0, 0, 0, 0, 0, 1, 4'hE);
      passo(0, 0, 0, 0, 0, 0, 0, 4'hE);
      passo(0, 1, 0, 0, 0, 0, 0, 4'h1);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h2);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h3);
`else
      passo(0, 0, 0, 0, 0, 0, 1, 4'h3);
      passo(0, 0, 0, 0, 0, 0, 1, 4'h3);
`endif
      // reach ESPERA_ESCRITA, then reset aborts before any write
      passo(0, 0, 1, 0, 0, 0, 0, 4'h4);
      passo(0, 0, 0, 1, 1, 0, 0, 4'h5);
      passo(0, 0, 0, 1, 1, 0, 0, 4'h7);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h8);
      passo(1, 0, 1, 0, 0, 0, 0, 4'h0);
      passo(0, 0, 0, 0, 0, 0, 0, 4'h0);
      verifica("scoreboard_drenado", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
